// File: rtl/rx_sweep_ctrl.sv
// rx_sweep_ctrl
// Sequencer for one RX downconversion channel. It steps the NCO phase
// increment through a frequency sweep. After each step it throws away a
// programmable number of decimated-sample strobes so the channel can settle.
// It then averages 2^L decimated I/Q samples and hands out one result per
// sweep point over a valid/ready handshake.
//
// Ports
//   sys_clk, rst            clock, synchronous active-high reset
//   start, abort            sweep request (1 cycle) / terminate (priority)
//   cfg_phase_start/step    phase increment of point 0 / per-point step
//   cfg_npoints, cfg_settle number of points / strobes dropped per step
//   cfg_log2_avg            log2 of averaging length (clamped to MAXL)
//   ce_down, rx_x, rx_y     decimated strobe and signed I/Q samples
//   phase_inc               phase increment driven to the RX channel NCO
//   busy, done              sweep active / end-of-sweep pulse
//   res_valid, res_ready    result handshake
//   res_index, res_phase_inc, res_x, res_y   result payload
module rx_sweep_ctrl #(
   parameter int PW    = 19,
   parameter int RX_OW = 16,
   parameter int CW    = 16,
   parameter int MAXL  = 8
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PW-1:0]    cfg_phase_start,
   input  logic [PW-1:0]    cfg_phase_step,
   input  logic [CW-1:0]    cfg_npoints,
   input  logic [CW-1:0]    cfg_settle,
   input  logic [3:0]       cfg_log2_avg,
   input  logic             ce_down,
   input  logic [RX_OW-1:0] rx_x,
   input  logic [RX_OW-1:0] rx_y,
   output logic [PW-1:0]    phase_inc,
   output logic             busy,
   output logic             done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CW-1:0]    res_index,
   output logic [PW-1:0]    res_phase_inc,
   output logic [RX_OW-1:0] res_x,
   output logic [RX_OW-1:0] res_y
);

   localparam int AW = RX_OW + MAXL;
   localparam int SW = MAXL + 1;
   localparam logic [3:0] MAXL_L = 4'(MAXL);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_ACCUM  = 2'd2;
   localparam logic [1:0] S_OUTPUT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    phaseInc_q, phaseInc_d;
   logic [PW-1:0]    phaseStep_q, phaseStep_d;
   logic [CW-1:0]    nPoints_q, nPoints_d;
   logic [CW-1:0]    settle_q, settle_d;
   logic [3:0]       log2Avg_q, log2Avg_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    settleCnt_q, settleCnt_d;
   logic [SW-1:0]    smpCnt_q, smpCnt_d;
   logic [AW-1:0]    accX_q, accX_d;
   logic [AW-1:0]    accY_q, accY_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             resValid_q, resValid_d;
   logic [CW-1:0]    resIndex_q, resIndex_d;
   logic [PW-1:0]    resPhase_q, resPhase_d;
   logic [RX_OW-1:0] resX_q, resX_d;
   logic [RX_OW-1:0] resY_q, resY_d;

   logic [AW-1:0]    sumX, sumY;
   logic [AW-1:0]    avgX, avgY;
   logic [SW-1:0]    smpNext, smpTarget;
   logic [3:0]       log2Clamped;
   logic             lastPoint;

   // Datapath helpers: running sum including the current sample, and the
   // average as an arithmetic shift (floor division by 2^L). The accumulator
   // carries MAXL guard bits so 2^MAXL full-scale samples cannot overflow.
   always_comb begin
      sumX        = accX_q + {{MAXL{rx_x[RX_OW-1]}}, rx_x};
      sumY        = accY_q + {{MAXL{rx_y[RX_OW-1]}}, rx_y};
      avgX        = AW'($signed(sumX) >>> log2Avg_q);
      avgY        = AW'($signed(sumY) >>> log2Avg_q);
      smpNext     = smpCnt_q + SW'(1);
      smpTarget   = SW'(1) << log2Avg_q;
      log2Clamped = (cfg_log2_avg > MAXL_L) ? MAXL_L : cfg_log2_avg;
      lastPoint   = (idx_q == nPoints_q - CW'(1));
   end

   // Sweep sequencer: IDLE -> SETTLE -> ACCUM -> OUTPUT -> (SETTLE | IDLE).
   // Abort is applied last so it overrides whatever the state logic chose,
   // while leaving phase_inc at its current value.
   always_comb begin
      state_d     = state_q;
      phaseInc_d  = phaseInc_q;
      phaseStep_d = phaseStep_q;
      nPoints_d   = nPoints_q;
      settle_d    = settle_q;
      log2Avg_d   = log2Avg_q;
      idx_d       = idx_q;
      settleCnt_d = settleCnt_q;
      smpCnt_d    = smpCnt_q;
      accX_d      = accX_q;
      accY_d      = accY_q;
      done_d      = 1'b0;
      resValid_d  = resValid_q;
      resIndex_d  = resIndex_q;
      resPhase_d  = resPhase_q;
      resX_d      = resX_q;
      resY_d      = resY_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               phaseStep_d = cfg_phase_step;
               nPoints_d   = cfg_npoints;
               settle_d    = cfg_settle;
               log2Avg_d   = log2Clamped;
               if (cfg_npoints == '0) begin
                  done_d = 1'b1;
               end else begin
                  phaseInc_d  = cfg_phase_start;
                  idx_d       = '0;
                  settleCnt_d = '0;
                  state_d     = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (settleCnt_q == settle_q) begin
               accX_d   = '0;
               accY_d   = '0;
               smpCnt_d = '0;
               state_d  = S_ACCUM;
            end else if (ce_down) begin
               settleCnt_d = settleCnt_q + CW'(1);
            end
         end
         S_ACCUM: begin
            if (ce_down) begin
               if (smpNext == smpTarget) begin
                  resX_d     = avgX[RX_OW-1:0];
                  resY_d     = avgY[RX_OW-1:0];
                  resIndex_d = idx_q;
                  resPhase_d = phaseInc_q;
                  resValid_d = 1'b1;
                  state_d    = S_OUTPUT;
               end else begin
                  accX_d   = sumX;
                  accY_d   = sumY;
                  smpCnt_d = smpNext;
               end
            end
         end
         default: begin
            if (resValid_q && res_ready) begin
               resValid_d = 1'b0;
               if (lastPoint) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d       = idx_q + CW'(1);
                  phaseInc_d  = phaseInc_q + phaseStep_q;
                  settleCnt_d = '0;
                  state_d     = S_SETTLE;
               end
            end
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         resValid_d = 1'b0;
         done_d     = 1'b0;
         phaseInc_d = phaseInc_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phaseInc_q  <= '0;
         phaseStep_q <= '0;
         nPoints_q   <= '0;
         settle_q    <= '0;
         log2Avg_q   <= '0;
         idx_q       <= '0;
         settleCnt_q <= '0;
         smpCnt_q    <= '0;
         accX_q      <= '0;
         accY_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         resValid_q  <= 1'b0;
         resIndex_q  <= '0;
         resPhase_q  <= '0;
         resX_q      <= '0;
         resY_q      <= '0;
      end else begin
         state_q     <= state_d;
         phaseInc_q  <= phaseInc_d;
         phaseStep_q <= phaseStep_d;
         nPoints_q   <= nPoints_d;
         settle_q    <= settle_d;
         log2Avg_q   <= log2Avg_d;
         idx_q       <= idx_d;
         settleCnt_q <= settleCnt_d;
         smpCnt_q    <= smpCnt_d;
         accX_q      <= accX_d;
         accY_q      <= accY_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         resValid_q  <= resValid_d;
         resIndex_q  <= resIndex_d;
         resPhase_q  <= resPhase_d;
         resX_q      <= resX_d;
         resY_q      <= resY_d;
      end
   end

   assign phase_inc     = phaseInc_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign res_valid     = resValid_q;
   assign res_index     = resIndex_q;
   assign res_phase_inc = resPhase_q;
   assign res_x         = resX_q;
   assign res_y         = resY_q;

endmodule

// File: tb/tb_rx_sweep_ctrl.sv
// tb_rx_sweep_ctrl
// Testbench for rx_sweep_ctrl. Every input sample the DUT sees is logged per
// clock edge. Expected averages are recomputed from that log using the sweep
// rules: skip the settle strobes, drop one cycle, then floor-average the next
// 2^L strobes.
module tb_rx_sweep_ctrl;

   localparam int PW    = 19;
   localparam int RX_OW = 16;
   localparam int CW    = 16;
   localparam int MAXL  = 8;
   localparam int LOGN  = 65536;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, abort;
   logic [PW-1:0]    cfg_phase_start, cfg_phase_step;
   logic [CW-1:0]    cfg_npoints, cfg_settle;
   logic [3:0]       cfg_log2_avg;
   logic             ce_down;
   logic [RX_OW-1:0] rx_x, rx_y;
   logic [PW-1:0]    phase_inc;
   logic             busy, done, res_valid, res_ready;
   logic [CW-1:0]    res_index;
   logic [PW-1:0]    res_phase_inc;
   logic [RX_OW-1:0] res_x, res_y;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic        ce_log [LOGN];
   logic [15:0] x_log  [LOGN];
   logic [15:0] y_log  [LOGN];

   int          ce_period = 1;
   int          smp_mode  = 0;
   int          strobe_n  = 0;
   logic [15:0] fix_x, fix_y;

   int          n_results, n_done;
   logic [15:0] got_idx [16];
   logic [18:0] got_ph  [16];
   logic [15:0] got_x   [16];
   logic [15:0] got_y   [16];

   rx_sweep_ctrl #(.PW(PW), .RX_OW(RX_OW), .CW(CW), .MAXL(MAXL)) dut (
      .sys_clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_phase_start(cfg_phase_start), .cfg_phase_step(cfg_phase_step),
      .cfg_npoints(cfg_npoints), .cfg_settle(cfg_settle),
      .cfg_log2_avg(cfg_log2_avg), .ce_down(ce_down), .rx_x(rx_x), .rx_y(rx_y),
      .phase_inc(phase_inc), .busy(busy), .done(done), .res_valid(res_valid),
      .res_ready(res_ready), .res_index(res_index),
      .res_phase_inc(res_phase_inc), .res_x(res_x), .res_y(res_y)
   );

   always #5 clk = ~clk;

   // Record what the DUT samples at each rising edge.
   always @(posedge clk) begin
      ce_log[cyc % LOGN] = ce_down;
      x_log[cyc % LOGN]  = rx_x;
      y_log[cyc % LOGN]  = rx_y;
      cyc = cyc + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the strobe and samples for the next edge.
   task automatic applyStimulus();
      if (ce_period == 0) ce_down = 1'($urandom_range(0, 1));
      else                ce_down = ((cyc % ce_period) == 0);
      case (smp_mode)
         0: begin rx_x = 16'($urandom); rx_y = 16'($urandom); end
         1: begin rx_x = fix_x; rx_y = fix_y; end
         default: begin rx_x = fix_x; rx_y = strobe_n[0] ? 16'hFFFE : 16'hFFFF; end
      endcase
      if (ce_down) strobe_n++;
   endtask

   // Reference average for a point whose settle phase starts at edge e.
   function automatic void model(input int e, input int settle, input int lg,
                                 output logic [15:0] ex, output logic [15:0] ey,
                                 output bit ok);
      int k, c, n, L;
      longint sx, sy;
      L = (lg > MAXL) ? MAXL : lg;
      k = e; c = 0; ok = 1; sx = 0; sy = 0; ex = '0; ey = '0;
      while (c < settle) begin
         if (k >= cyc) begin ok = 0; return; end
         if (ce_log[k % LOGN]) c++;
         k++;
      end
      k++;
      n = 0;
      while (n < (1 << L)) begin
         if (k >= cyc) begin ok = 0; return; end
         if (ce_log[k % LOGN]) begin
            sx += longint'($signed(x_log[k % LOGN]));
            sy += longint'($signed(y_log[k % LOGN]));
            n++;
         end
         k++;
      end
      ex = 16'(sx >>> L);
      ey = 16'(sy >>> L);
   endfunction

   // Full sweep with per-cycle checking of phase, busy, results and stability.
   task automatic run_sweep(input logic [18:0] ps, input logic [18:0] st,
                            input int npts, input int settle, input int lg,
                            input int hold_pt, input int hold_cycles,
                            input int busy_start_at, input bit rdy_rand);
      int pt, chg, hold_cnt;
      bit seen, done_seen, ok;
      logic [18:0] exp_ph;
      logic [15:0] ex, ey;
      logic [66:0] snap;
      cfg_phase_start = ps; cfg_phase_step = st;
      cfg_npoints = 16'(npts); cfg_settle = 16'(settle); cfg_log2_avg = 4'(lg);
      start = 1'b1; abort = 1'b0; res_ready = 1'b0;
      applyStimulus();
      chg = cyc;
      tick();
      pt = 0; exp_ph = ps; n_results = 0; n_done = 0;
      seen = 0; done_seen = 0; hold_cnt = 0; snap = '0;
      for (int iter = 0; iter < 20000; iter++) begin
         if (done === 1'b1) begin
            done_seen = 1; n_done++;
            n_checks++;
            if (busy !== 1'b0 || res_valid !== 1'b0) begin
               n_fail++; $display("[TB] FAIL done_state: busy=%0b res_valid=%0b required 0/0", busy, res_valid);
            end
            n_checks++;
            if (n_results != npts) begin
               n_fail++; $display("[TB] FAIL result_count: got %0d required %0d", n_results, npts);
            end
            n_checks++;
            if (phase_inc !== exp_ph) begin
               n_fail++; $display("[TB] FAIL final_phase: got %0d required %0d", phase_inc, exp_ph);
            end
            break;
         end
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL busy_run: got %0b required 1", busy);
         end
         n_checks++;
         if (phase_inc !== exp_ph) begin
            n_fail++; $display("[TB] FAIL phase_inc: got %0d required %0d", phase_inc, exp_ph);
         end
         if (res_valid === 1'b1) begin
            if (!seen) begin
               model(chg + 1, settle, lg, ex, ey, ok);
               n_checks++;
               if (!ok) begin
                  n_fail++; $display("[TB] FAIL early_result: point %0d valid before enough samples", pt);
               end
               n_checks++;
               if (res_index !== 16'(pt) || res_phase_inc !== exp_ph) begin
                  n_fail++; $display("[TB] FAIL res_tag: got idx %0d ph %0d required idx %0d ph %0d", res_index, res_phase_inc, pt, exp_ph);
               end
               n_checks++;
               if (res_x !== ex || res_y !== ey) begin
                  n_fail++; $display("[TB] FAIL res_avg: got x %0d y %0d required x %0d y %0d", $signed(res_x), $signed(res_y), $signed(ex), $signed(ey));
               end
               if (n_results < 16) begin
                  got_idx[n_results] = res_index; got_ph[n_results] = res_phase_inc;
                  got_x[n_results] = res_x; got_y[n_results] = res_y;
               end
               n_results++;
               snap = {res_index, res_phase_inc, res_x, res_y};
               seen = 1;
            end else begin
               n_checks++;
               if ({res_index, res_phase_inc, res_x, res_y} !== snap) begin
                  n_fail++; $display("[TB] FAIL res_stable: got %0h required %0h", {res_index, res_phase_inc, res_x, res_y}, snap);
               end
            end
         end
         start = 1'b0;
         if (iter == busy_start_at) begin
            start = 1'b1;
            cfg_phase_start = 19'($urandom); cfg_phase_step = 19'($urandom);
            cfg_npoints = 16'($urandom_range(1, 9)); cfg_settle = 16'($urandom_range(0, 9));
            cfg_log2_avg = 4'($urandom);
         end
         if (pt == hold_pt && hold_cnt < hold_cycles) res_ready = 1'b0;
         else res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (res_valid === 1'b1 && pt == hold_pt) hold_cnt++;
         applyStimulus();
         if (res_valid === 1'b1 && res_ready) begin
            chg = cyc; seen = 0;
            if (pt != npts - 1) begin
               pt++;
               exp_ph = exp_ph + st;
            end
         end
         tick();
      end
      start = 1'b0;
      n_checks++;
      if (!done_seen) begin
         n_fail++; $display("[TB] FAIL sweep_timeout: done seen %0b required 1", done_seen);
      end
      applyStimulus();
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("[TB] FAIL after_done: done=%0b busy=%0b required 0/0", done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; ce_down = 1'b0;
      tick(); tick();
      n_checks++;
      if (phase_inc !== '0 || busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL reset_ctrl: ph %0d busy %0b done %0b valid %0b required all 0", phase_inc, busy, done, res_valid);
      end
      n_checks++;
      if (res_index !== '0 || res_phase_inc !== '0 || res_x !== '0 || res_y !== '0) begin
         n_fail++; $display("[TB] FAIL reset_res: idx %0d ph %0d x %0h y %0h required all 0", res_index, res_phase_inc, res_x, res_y);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      ce_period = 4; smp_mode = 1; fix_x = 16'd100; fix_y = 16'hFFFD;
      run_sweep(19'd1000, 19'd500, 3, 2, 2, -1, 0, -1, 0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (got_idx[i] !== 16'(i) || got_ph[i] !== 19'(1000 + 500 * i) || got_x[i] !== 16'd100 || got_y[i] !== 16'hFFFD) begin
            n_fail++; $display("[TB] FAIL basic_point%0d: idx %0d ph %0d x %0h y %0h", i, got_idx[i], got_ph[i], got_x[i], got_y[i]);
         end
      end
      n_checks++;
      if (n_done != 1 || phase_inc !== 19'd2000) begin
         n_fail++; $display("[TB] FAIL basic_end: done count %0d ph %0d required 1 / 2000", n_done, phase_inc);
      end
   endtask

   task automatic test_backpressure();
      ce_period = 0; smp_mode = 0;
      run_sweep(19'd5000, 19'd1234, 3, 1, 2, 1, 20, -1, 0);
   endtask

   task automatic test_wrap();
      ce_period = 2; smp_mode = 0;
      run_sweep(19'(524288 - 100), 19'd200, 2, 0, 1, -1, 0, -1, 0);
      n_checks++;
      if (got_ph[1] !== 19'd100) begin
         n_fail++; $display("[TB] FAIL wrap_phase: got %0d required 100", got_ph[1]);
      end
   endtask

   task automatic test_busy_start();
      ce_period = 0; smp_mode = 0;
      run_sweep(19'd777, 19'd3333, 2, 3, 2, -1, 0, 2, 1);
   endtask

   task automatic test_abort();
      ce_period = 1; smp_mode = 0;
      cfg_phase_start = 19'd4242; cfg_phase_step = 19'd10; cfg_npoints = 16'd4;
      cfg_settle = 16'd1; cfg_log2_avg = 4'd4; res_ready = 1'b1;
      start = 1'b1; applyStimulus(); tick(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin applyStimulus(); tick(); end
      n_checks++;
      if (busy !== 1'b1 || res_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL abort_pre: busy %0b valid %0b required 1/0", busy, res_valid);
      end
      abort = 1'b1; applyStimulus(); tick(); abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || phase_inc !== 19'd4242) begin
         n_fail++; $display("[TB] FAIL abort_now: busy %0b ph %0d required 0/4242", busy, phase_inc);
      end
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_quiet: valid %0b done %0b busy %0b required 0", res_valid, done, busy);
         end
         applyStimulus(); tick();
      end
      start = 1'b1; abort = 1'b1; applyStimulus(); tick(); start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || phase_inc !== 19'd4242) begin
            n_fail++; $display("[TB] FAIL start_abort: busy %0b done %0b ph %0d required 0/0/4242", busy, done, phase_inc);
         end
         applyStimulus(); tick();
      end
   endtask

   task automatic test_empty();
      cfg_npoints = '0; cfg_phase_start = 19'd9; start = 1'b1;
      applyStimulus(); tick(); start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("[TB] FAIL empty_done: done %0b busy %0b required 1/0", done, busy);
      end
      applyStimulus(); tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("[TB] FAIL empty_after: done %0b busy %0b required 0/0", done, busy);
      end
   endtask

   task automatic test_settle0_l0();
      ce_period = 0; smp_mode = 0;
      run_sweep(19'd12345, 19'd7, 3, 0, 0, -1, 0, -1, 1);
   endtask

   task automatic test_rounding();
      ce_period = 0; smp_mode = 2; fix_x = 16'd5;
      run_sweep(19'd100, 19'd100, 3, 1, 1, -1, 0, -1, 0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (got_y[i] !== 16'hFFFE) begin
            n_fail++; $display("[TB] FAIL round_y%0d: got %0d required -2", i, $signed(got_y[i]));
         end
      end
   endtask

   task automatic test_clamp();
      ce_period = 1; smp_mode = 0;
      run_sweep(19'd333, 19'd1, 1, 2, 12, -1, 0, -1, 0);
   endtask

   task automatic test_fullscale();
      ce_period = 1; smp_mode = 1; fix_x = 16'h8000; fix_y = 16'h7FFF;
      run_sweep(19'd50, 19'd1, 1, 0, 8, -1, 0, -1, 0);
      n_checks++;
      if (got_x[0] !== 16'h8000 || got_y[0] !== 16'h7FFF) begin
         n_fail++; $display("[TB] FAIL fullscale: x %0h y %0h required 8000/7fff", got_x[0], got_y[0]);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         ce_period = 0; smp_mode = 0;
         run_sweep(19'($urandom), 19'($urandom), $urandom_range(1, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4), -1, 0, -1, 1);
      end
   endtask

   initial begin
      fix_x = '0; fix_y = '0; rx_x = '0; rx_y = '0;
      cfg_phase_start = '0; cfg_phase_step = '0; cfg_npoints = '0;
      cfg_settle = '0; cfg_log2_avg = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_busy_start();
      test_abort();
      test_empty();
      test_settle0_l0();
      test_rounding();
      test_clamp();
      test_fullscale();
      test_random();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
